fir_decim_mc: RTL and testbench

Multi-channel, time-multiplexed decimating FIR filter for the audio path. It is the parametrised successor to the fixed single-channel pre-filter and sits between the PSG/FM mixer output (high-rate samples) and the resampler/DAC feed. It uses signed fixed-point arithmetic, runtime-loadable coefficients, valid/ready handshakes on both sides, an integer decimation factor, and output saturation with a sticky overflow flag.

---
 rtl/fir_decim_mc.sv | 169 ++++++++++++++++
 tb/tb_fir_decim_mc.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_decim_mc.sv
// fir_decim_mc: time-multiplexed multi-channel decimating FIR filter with
// runtime-loadable coefficients, round-half-up, output saturation and sticky overflow.
module fir_decim_mc #(
    parameter int IW       = 16,
    parameter int CW       = 16,
    parameter int TAPS     = 32,
    parameter int CHANNELS = 2,
    parameter int DECIM    = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [CHANNELS*IW-1:0]   i_in_data,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [CHANNELS*IW-1:0]   o_out_data,
    input  logic                     i_coef_we,
    input  logic [$clog2(TAPS)-1:0]  i_coef_addr,
    input  logic [CW-1:0]            i_coef_data,
    output logic                     o_coef_err,
    output logic                     o_overflow
);
    localparam int AW   = $clog2(TAPS);
    localparam int PW   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int PRW  = IW + CW;
    localparam int ACCW = IW + CW + AW;
    localparam logic signed [ACCW-1:0] RND_HALF = ACCW'(2 ** (CW - 2));
    localparam logic signed [ACCW-1:0] SAT_MAX  = ACCW'(2 ** (IW - 1) - 1);
    localparam logic signed [ACCW-1:0] SAT_MIN  = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_ROUND = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                  r_state;
    logic [AW-1:0]           r_wp;
    logic [AW-1:0]           r_k;
    logic [PW-1:0]           r_ph;
    logic signed [IW-1:0]    r_x    [CHANNELS][TAPS];
    logic signed [CW-1:0]    r_coef [TAPS];
    logic signed [ACCW-1:0]  r_acc  [CHANNELS];
    logic [CHANNELS*IW-1:0]  r_sat;
    logic                    r_clamp;

    logic                    w_accept;
    logic                    w_trigger;
    logic [AW-1:0]           w_rd_idx;
    logic signed [PRW-1:0]   w_prod [CHANNELS];
    logic signed [ACCW-1:0]  w_rnd  [CHANNELS];
    logic [CHANNELS*IW-1:0]  w_sat;
    logic                    w_clamp;

    assign w_accept  = i_in_valid & o_in_ready;
    assign w_trigger = w_accept & (r_ph == PW'(DECIM - 1));
    // Tap k reads x[n-k]; wp already points one past the newest sample.
    assign w_rd_idx  = r_wp - AW'(1) - r_k;

    // One multiplier per channel, shared across taps.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_prod[c] = PRW'(r_x[c][w_rd_idx]) * PRW'(r_coef[r_k]);
        end
    end

    // Round half toward +inf, then clamp to the output sample range.
    always_comb begin
        w_sat   = '0;
        w_clamp = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_rnd[c] = (r_acc[c] + RND_HALF) >>> (CW - 1);
            if (w_rnd[c] > SAT_MAX) begin
                w_sat[c*IW +: IW] = SAT_MAX[IW-1:0];
                w_clamp           = 1'b1;
            end else if (w_rnd[c] < SAT_MIN) begin
                w_sat[c*IW +: IW] = SAT_MIN[IW-1:0];
                w_clamp           = 1'b1;
            end else begin
                w_sat[c*IW +: IW] = w_rnd[c][IW-1:0];
            end
        end
    end

    // Control FSM with sample ring buffers, coefficient table, accumulators and outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wp        <= '0;
            r_k         <= '0;
            r_ph        <= '0;
            r_sat       <= '0;
            r_clamp     <= 1'b0;
            o_in_ready  <= 1'b1;
            o_out_valid <= 1'b0;
            o_out_data  <= '0;
            o_coef_err  <= 1'b0;
            o_overflow  <= 1'b0;
            for (int t = 0; t < TAPS; t++) begin
                r_coef[t] <= '0;
            end
            for (int c = 0; c < CHANNELS; c++) begin
                r_acc[c] <= '0;
                for (int t = 0; t < TAPS; t++) begin
                    r_x[c][t] <= '0;
                end
            end
        end else begin
            o_coef_err <= i_coef_we & (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (i_coef_we) begin
                        r_coef[i_coef_addr] <= i_coef_data;
                    end
                    if (w_accept) begin
                        for (int c = 0; c < CHANNELS; c++) begin
                            r_x[c][r_wp] <= i_in_data[c*IW +: IW];
                        end
                        r_wp <= r_wp + AW'(1);
                        r_ph <= (r_ph == PW'(DECIM - 1)) ? '0 : r_ph + PW'(1);
                        if (w_trigger) begin
                            r_state    <= S_MAC;
                            o_in_ready <= 1'b0;
                            r_k        <= '0;
                            for (int c = 0; c < CHANNELS; c++) begin
                                r_acc[c] <= '0;
                            end
                        end
                    end
                end
                S_MAC: begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        r_acc[c] <= r_acc[c] + ACCW'(w_prod[c]);
                    end
                    r_k <= r_k + AW'(1);
                    if (r_k == AW'(TAPS - 1)) begin
                        r_state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_sat   <= w_sat;
                    r_clamp <= w_clamp;
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    if (!o_out_valid) begin
                        o_out_data  <= r_sat;
                        o_out_valid <= 1'b1;
                        if (r_clamp) begin
                            o_overflow <= 1'b1;
                        end
                    end else if (i_out_ready) begin
                        o_out_valid <= 1'b0;
                        o_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    o_in_ready  <= 1'b1;
                    o_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_decim_mc.sv
// Scoreboard bench for fir_decim_mc: a history-based reference model predicts
// each decimated output; a monitor pops and compares on every output handshake.
module tb_fir_decim_mc;
    localparam int IW    = 16;
    localparam int CW    = 16;
    localparam int TAPS  = 32;
    localparam int CH    = 2;
    localparam int DECIM = 6;
    localparam int AW    = $clog2(TAPS);
    localparam longint MAXV = (64'sd1 <<< (IW - 1)) - 64'sd1;
    localparam longint MINV = -(64'sd1 <<< (IW - 1));

    logic              clk = 1'b0;
    logic              reset;
    logic              i_in_valid;
    logic              o_in_ready;
    logic [CH*IW-1:0]  i_in_data;
    logic              o_out_valid;
    logic              i_out_ready;
    logic [CH*IW-1:0]  o_out_data;
    logic              i_coef_we;
    logic [AW-1:0]     i_coef_addr;
    logic [CW-1:0]     i_coef_data;
    logic              o_coef_err;
    logic              o_overflow;

    fir_decim_mc #(.IW(IW), .CW(CW), .TAPS(TAPS), .CHANNELS(CH), .DECIM(DECIM)) dut (
        .clk(clk), .reset(reset),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
        .i_coef_we(i_coef_we), .i_coef_addr(i_coef_addr), .i_coef_data(i_coef_data),
        .o_coef_err(o_coef_err), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH*IW-1:0] data;
        bit               ovf;
        int               t;
    } exp_t;

    exp_t   exp_q[$];
    longint hist0[$];
    longint hist1[$];
    longint coef_m [TAPS];
    int     n_cmp = 0;
    int     n_fail = 0;
    int     cyc = 0;
    int     n_out = 0;
    int     nacc = 0;
    int     rdy_mode = 0;
    bit     ovf_m = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
        end
    endtask

    // Direct-form convolution over the full accepted history (reset zeros before it).
    function automatic longint conv(input int c);
        longint acc = 0;
        int     n;
        n = (c == 0) ? hist0.size() - 1 : hist1.size() - 1;
        for (int k = 0; k < TAPS; k++) begin
            if (n - k >= 0) acc += ((c == 0) ? hist0[n - k] : hist1[n - k]) * coef_m[k];
        end
        return acc;
    endfunction

    task automatic model_accept(input longint d0, input longint d1, input int t);
        exp_t   e;
        longint r;
        hist0.push_back(d0);
        hist1.push_back(d1);
        nacc++;
        if (nacc % DECIM == 0) begin
            e.data = '0;
            for (int c = 0; c < CH; c++) begin
                r = (conv(c) + (64'sd1 <<< (CW - 2))) >>> (CW - 1);
                if (r > MAXV) begin
                    r = MAXV; ovf_m = 1'b1;
                end else if (r < MINV) begin
                    r = MINV; ovf_m = 1'b1;
                end
                e.data[c*IW +: IW] = r[IW-1:0];
            end
            e.ovf = ovf_m;
            e.t   = t;
            exp_q.push_back(e);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        hist0.delete();
        hist1.delete();
        nacc  = 0;
        ovf_m = 1'b0;
        for (int k = 0; k < TAPS; k++) coef_m[k] = 0;
    endtask

    task automatic wait_ready(output bit ok);
        int g = 0;
        @(negedge clk);
        while (!o_in_ready && g < 400) begin
            @(negedge clk);
            g++;
        end
        ok = o_in_ready;
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL in_ready_timeout: in_ready stayed 0 for %0d cycles, expected 1", g);
        end
    endtask

    task automatic send_frame(input int d0, input int d1, input bit wc, input int ca, input int cd);
        bit               ok;
        logic [CH*IW-1:0] v;
        int               t0;
        int               t1;
        wait_ready(ok);
        if (ok) begin
            t0 = d0; t1 = d1;
            v[0 +: IW]  = t0[IW-1:0];
            v[IW +: IW] = t1[IW-1:0];
            i_in_valid  = 1'b1;
            i_in_data   = v;
            i_coef_we   = wc;
            i_coef_addr = ca[AW-1:0];
            i_coef_data = cd[CW-1:0];
            if (wc) coef_m[ca] = cd;
            model_accept(d0, d1, cyc + 1);
            @(posedge clk); #1;
            i_in_valid = 1'b0;
            i_coef_we  = 1'b0;
        end
    endtask

    task automatic write_coef(input int a, input int d);
        bit ok;
        wait_ready(ok);
        if (ok) begin
            i_coef_we   = 1'b1;
            i_coef_addr = a[AW-1:0];
            i_coef_data = d[CW-1:0];
            coef_m[a]   = d;
            @(posedge clk); #1;
            i_coef_we = 1'b0;
            @(negedge clk);
            chk("coef_err_idle_write", o_coef_err, 0);
        end
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() > 0 && g < 3000) begin
            @(posedge clk);
            g++;
        end
        chk("drain_pending_outputs", exp_q.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    function automatic int rnd_s(input int lim);
        return int'($urandom_range(0, 2 * lim)) - lim;
    endfunction

    // Output-side back-pressure pattern.
    initial begin
        i_out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       i_out_ready = 1'b1;
                1:       i_out_ready = 1'($urandom_range(0, 1));
                default: i_out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: latency, stability under back-pressure, and scoreboard compare.
    initial begin : mon
        bit               seen;
        logic [CH*IW-1:0] held;
        exp_t             e;
        seen = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                seen = 1'b0;
            end else if (o_out_valid) begin
                chk("in_ready_low_while_out_valid", o_in_ready, 0);
                if (!seen) begin
                    seen = 1'b1;
                    held = o_out_data;
                    chk("expected_output_pending", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) chk("trigger_to_valid_latency", cyc - exp_q[0].t, TAPS + 2);
                end else begin
                    chk("out_data_stable", o_out_data, held);
                end
                if (i_out_ready) begin
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("out_data", o_out_data, e.data);
                        chk("overflow", o_overflow, e.ovf);
                        n_out++;
                    end
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        reset       = 1'b1;
        i_in_valid  = 1'b0;
        i_in_data   = '0;
        i_coef_we   = 1'b0;
        i_coef_addr = '0;
        i_coef_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", o_in_ready, 1);
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_out_data", o_out_data, 0);
        chk("rst_overflow", o_overflow, 0);
        chk("rst_coef_err", o_coef_err, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Impulse response with c[k] = k*256; channel 1 carries a scaled, negated impulse.
        for (int k = 0; k < TAPS; k++) write_coef(k, k * 256);
        send_frame(16384, -8192, 1'b0, 0, 0);
        for (int i = 1; i < 36; i++) send_frame(0, 0, 1'b0, 0, 0);
        drain();

        // Rounding: only c[0] = 0.5; distinct data per channel.
        write_coef(0, 16384);
        for (int k = 1; k < TAPS; k++) write_coef(k, 0);
        for (int i = 0; i < 12; i++) begin
            if (i % DECIM == DECIM - 1) send_frame((i < 6) ? 1001 : -1001, (i < 6) ? -1001 : 1001, 1'b0, 0, 0);
            else send_frame(rnd_s(30000), rnd_s(30000), 1'b0, 0, 0);
        end
        drain();

        // Saturation both ways, then zeros; overflow stays set.
        for (int k = 0; k < TAPS; k++) write_coef(k, 32767);
        for (int i = 0; i < 36; i++) send_frame(32767, 32767, 1'b0, 0, 0);
        for (int i = 0; i < 36; i++) send_frame(-32768, -32768, 1'b0, 0, 0);
        for (int i = 0; i < 36; i++) send_frame(0, 0, 1'b0, 0, 0);
        drain();
        chk("overflow_sticky_after_zeros", o_overflow, 1);

        // Decimation with a long output stall.
        for (int k = 0; k < TAPS; k++) write_coef(k, rnd_s(4096));
        n0 = n_out;
        rdy_mode = 2;
        for (int i = 0; i < 6; i++) send_frame(rnd_s(20000), rnd_s(20000), 1'b0, 0, 0);
        repeat (TAPS + 2 + 50) @(posedge clk);
        rdy_mode = 0;
        for (int i = 0; i < 6; i++) send_frame(rnd_s(20000), rnd_s(20000), 1'b0, 0, 0);
        drain();
        chk("decim_12_frames_2_outputs", n_out - n0, 2);

        // Coefficient write during MAC is rejected; the same write in IDLE applies.
        for (int i = 0; i < 6; i++) send_frame(rnd_s(20000), rnd_s(20000), 1'b0, 0, 0);
        repeat (3) @(posedge clk); #1;
        i_coef_we   = 1'b1;
        i_coef_addr = AW'(3);
        i_coef_data = CW'(12345);
        @(posedge clk); #1;
        i_coef_we = 1'b0;
        @(negedge clk);
        chk("coef_err_pulse", o_coef_err, 1);
        @(negedge clk);
        chk("coef_err_one_cycle", o_coef_err, 0);
        drain();
        write_coef(3, 12345);
        for (int i = 0; i < 6; i++) send_frame(rnd_s(20000), rnd_s(20000), 1'b0, 0, 0);
        drain();

        // Random traffic with random back-pressure and writes coinciding with accepts.
        rdy_mode = 1;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            if ($urandom_range(0, 4) == 0)
                send_frame(rnd_s(32768), rnd_s(32768), 1'b1, int'($urandom_range(0, TAPS - 1)), rnd_s(20000));
            else
                send_frame(rnd_s(32768), rnd_s(32768), 1'b0, 0, 0);
        end
        drain();
        rdy_mode = 0;

        // Reset during MAC, then a fresh impulse response.
        do send_frame(rnd_s(20000), rnd_s(20000), 1'b0, 0, 0); while (nacc % DECIM != 0);
        repeat (4) @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("midrst_in_ready", o_in_ready, 1);
        chk("midrst_out_valid", o_out_valid, 0);
        chk("midrst_out_data", o_out_data, 0);
        chk("midrst_overflow", o_overflow, 0);
        chk("midrst_coef_err", o_coef_err, 0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < TAPS; k++) write_coef(k, k * 256);
        send_frame(16384, -8192, 1'b0, 0, 0);
        for (int i = 1; i < 36; i++) send_frame(0, 0, 1'b0, 0, 0);
        drain();
        @(negedge clk);
        chk("idle_at_end", o_out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
